match_ctrl: RTL

- Game-level controller directly downstream of the ball stage.
- Consumes the ball's out_left/out_right edge events and keeps both players' scores.
- Drives the ball's reset and entropy inputs so that each point ends with a timed re-serve from centre.
- Declares game over at a fixed winning score; a start button begins a new match.

---
 rtl/match_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/match_ctrl.sv
// Match controller: scores ball edge events, times the re-serve from centre,
// declares the winner at WIN_SCORE and restarts on a start press.
module match_ctrl #(
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned SERVE_TICKS = 2000,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       out_left,
  input  logic       out_right,
  output logic       ball_reset,
  output logic [4:0] entropy,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic       serving
);

  localparam int unsigned         CNT_W    = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(SERVE_TICKS - 1);
  localparam logic [3:0]          WIN      = 4'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

  state_t           state_reg;
  logic [7:0]       lfsr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ol_q, or_q, st_q;
  logic             point_l, point_r, start_p;
  logic [3:0]       score_l_inc, score_r_inc;

  assign point_r     = out_left & ~ol_q;
  assign point_l     = out_right & ~or_q;
  assign start_p     = start & ~st_q;
  assign score_l_inc = score_l + 4'd1;
  assign score_r_inc = score_r + 4'd1;
  assign entropy     = lfsr_reg[4:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      lfsr_reg   <= LFSR_SEED;
      cnt_reg    <= '0;
      ol_q       <= 1'b0;
      or_q       <= 1'b0;
      st_q       <= 1'b0;
      score_l    <= 4'd0;
      score_r    <= 4'd0;
      ball_reset <= 1'b1;
      game_over  <= 1'b0;
      winner     <= 1'b0;
      serving    <= 1'b0;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
      // Edge history advances in every state so a held level never re-fires.
      ol_q <= out_left;
      or_q <= out_right;
      st_q <= start;

      case (state_reg)
        IDLE: begin
          if (start_p) begin
            state_reg <= SERVE;
            serving   <= 1'b1;
            cnt_reg   <= CNT_LOAD;
          end
        end

        SERVE: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else begin
            state_reg  <= PLAY;
            serving    <= 1'b0;
            ball_reset <= 1'b0;
          end
        end

        PLAY: begin
          // Simultaneous edges cancel: neither side is credited.
          if (point_l ^ point_r) begin
            ball_reset <= 1'b1;
            if (point_l) score_l <= score_l_inc;
            else         score_r <= score_r_inc;
            if ((point_l && score_l_inc == WIN) || (point_r && score_r_inc == WIN)) begin
              state_reg <= OVER;
              game_over <= 1'b1;
              winner    <= point_r;
            end else begin
              state_reg <= SERVE;
              serving   <= 1'b1;
              cnt_reg   <= CNT_LOAD;
            end
          end
        end

        OVER: begin
          if (start_p) begin
            state_reg <= SERVE;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            serving   <= 1'b1;
            cnt_reg   <= CNT_LOAD;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
